// File: rtl/dcache_pkg.sv
// Shared types and address-split constants for the two-way data cache controller.
package dcache_pkg;

    localparam int TAG_W   = 27;
    localparam int IDX_BIT = 4;
    localparam int OFF_W   = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        WB   = S_WB,
        FILL = S_FILL
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             valid;
        logic             dirty;
    } line_meta_t;

endpackage

// File: rtl/data_cache_ctrl_if.sv
// Word-wide memory bus used for copy-back writes and line refills.
interface data_cache_ctrl_if #(parameter int ADDR_W = 32);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr, output mem_ready);

endinterface

// File: rtl/dcache_tag_store.sv
// Tag/valid/dirty metadata for 2 sets x 2 ways plus one LRU bit per set.
module dcache_tag_store
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_idx,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit0,
    output logic             hit1,
    output logic             victim_way,
    output line_meta_t       victim_meta,
    input  logic             meta_we,
    input  logic             meta_idx,
    input  logic             meta_way,
    input  line_meta_t       meta_wdata,
    input  logic             lru_we,
    input  logic             lru_idx,
    input  logic             lru_wdata
);

    line_meta_t [3:0] meta_q, meta_d;
    logic [1:0]       lru_q, lru_d;
    line_meta_t       way0, way1;

    always_comb begin
        meta_d = meta_q;
        lru_d  = lru_q;
        if (meta_we) meta_d[{meta_idx, meta_way}] = meta_wdata;
        if (lru_we)  lru_d[lru_idx] = lru_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            lru_q  <= '0;
        end else begin
            meta_q <= meta_d;
            lru_q  <= lru_d;
        end
    end

    // An empty way is always preferred over evicting live data; way 0 wins ties.
    always_comb begin
        way0        = meta_q[{lookup_idx, 1'b0}];
        way1        = meta_q[{lookup_idx, 1'b1}];
        hit0        = way0.valid && (way0.tag == lookup_tag);
        hit1        = way1.valid && (way1.tag == lookup_tag);
        if (!way0.valid)      victim_way = 1'b0;
        else if (!way1.valid) victim_way = 1'b1;
        else                  victim_way = lru_q[lookup_idx];
        victim_meta = victim_way ? way1 : way0;
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// Hit/miss control for the 2-set, 2-way write-back data cache: lookup, copy-back and refill FSM.
module data_cache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              stall,
    output logic              index,
    output logic [OFF_W-1:0]  offset,
    output logic              hit,
    output logic              first,
    output logic              second,
    output logic [1:0]        w_sel,
    output logic [1:0]        copy,
    output logic              copy_back,
    output logic              cache_re,
    output logic              cache_we,
    output logic              cache_data_src,
    data_cache_ctrl_if.master mem
);

    localparam logic [1:0] LAST_W = 2'(WORDS - 1);

    state_e           state_q, state_d;
    logic [1:0]       w_q, w_d;
    logic             victim_q, victim_d;
    logic [TAG_W-1:0] victim_tag_q, victim_tag_d;

    logic             hit0, hit1, victim_way;
    line_meta_t       victim_meta;
    logic             meta_we, lru_we, lru_wdata, meta_way;
    line_meta_t       meta_wdata;
    logic             mem_req_c, mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [TAG_W-1:0] cpu_tag;

    assign cpu_tag = cpu_addr[ADDR_W-1:IDX_BIT+1];
    assign index   = cpu_addr[IDX_BIT];
    assign offset  = cpu_addr[OFF_W-1:0];

    assign mem.mem_req  = mem_req_c;
    assign mem.mem_we   = mem_we_c;
    assign mem.mem_addr = mem_addr_c;

    dcache_tag_store u_tags (
        .clk         (clk),
        .reset       (reset),
        .lookup_idx  (index),
        .lookup_tag  (cpu_tag),
        .hit0        (hit0),
        .hit1        (hit1),
        .victim_way  (victim_way),
        .victim_meta (victim_meta),
        .meta_we     (meta_we),
        .meta_idx    (index),
        .meta_way    (meta_way),
        .meta_wdata  (meta_wdata),
        .lru_we      (lru_we),
        .lru_idx     (index),
        .lru_wdata   (lru_wdata)
    );

    always_comb begin
        state_d        = state_q;
        w_d            = w_q;
        victim_d       = victim_q;
        victim_tag_d   = victim_tag_q;
        stall          = 1'b0;
        hit            = 1'b0;
        first          = 1'b0;
        second         = 1'b0;
        w_sel          = 2'b00;
        copy           = 2'b00;
        copy_back      = 1'b0;
        cache_re       = 1'b0;
        cache_we       = 1'b0;
        cache_data_src = 1'b0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_c     = '0;
        meta_we        = 1'b0;
        meta_way       = 1'b0;
        meta_wdata     = '0;
        lru_we         = 1'b0;
        lru_wdata      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_re || cpu_we) begin
                    if (hit0 || hit1) begin
                        hit       = 1'b1;
                        first     = hit0;
                        second    = hit1;
                        lru_we    = 1'b1;
                        lru_wdata = ~hit1;
                        // A simultaneous load/store is a load, so it never dirties the line.
                        if (cpu_re) begin
                            cache_re = 1'b1;
                            w_sel    = offset[3:2];
                        end else begin
                            cache_we   = 1'b1;
                            meta_we    = 1'b1;
                            meta_way   = hit1;
                            meta_wdata = '{tag: cpu_tag, valid: 1'b1, dirty: 1'b1};
                        end
                    end else begin
                        stall        = 1'b1;
                        victim_d     = victim_way;
                        victim_tag_d = victim_meta.tag;
                        w_d          = 2'b00;
                        state_d      = (victim_meta.valid && victim_meta.dirty) ? WB : FILL;
                    end
                end
            end
            WB: begin
                stall      = 1'b1;
                mem_req_c  = 1'b1;
                mem_we_c   = 1'b1;
                copy_back  = 1'b1;
                cache_re   = 1'b1;
                copy       = {index, victim_q};
                w_sel      = w_q;
                mem_addr_c = {victim_tag_q, index, w_q, 2'b00};
                if (mem.mem_ready) begin
                    w_d = w_q + 2'd1;
                    if (w_q == LAST_W) state_d = FILL;
                end
            end
            FILL: begin
                stall      = 1'b1;
                mem_req_c  = 1'b1;
                mem_addr_c = {cpu_tag, index, w_q, 2'b00};
                if (mem.mem_ready) begin
                    cache_we       = 1'b1;
                    cache_data_src = 1'b1;
                    first          = ~victim_q;
                    second         = victim_q;
                    w_sel          = w_q;
                    w_d            = w_q + 2'd1;
                    if (w_q == LAST_W) begin
                        meta_we    = 1'b1;
                        meta_way   = victim_q;
                        meta_wdata = '{tag: cpu_tag, valid: 1'b1, dirty: 1'b0};
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Keep the data array and memory quiet while reset is held, whatever the FSM state.
        if (reset) begin
            stall          = 1'b0;
            hit            = 1'b0;
            first          = 1'b0;
            second         = 1'b0;
            w_sel          = 2'b00;
            copy           = 2'b00;
            copy_back      = 1'b0;
            cache_re       = 1'b0;
            cache_we       = 1'b0;
            cache_data_src = 1'b0;
            mem_req_c      = 1'b0;
            mem_we_c       = 1'b0;
            mem_addr_c     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            w_q          <= 2'b00;
            victim_q     <= 1'b0;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            victim_q     <= victim_d;
            victim_tag_q <= victim_tag_d;
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl: directed loads/stores with queued memory-bus and hit expectations.
module tb_data_cache_ctrl;
    import dcache_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic        copy_back;
        logic [1:0]  copy;
        logic        cache_re;
        logic        cache_we;
        logic        data_src;
        logic        first;
        logic        second;
        logic [1:0]  w_sel;
    } mem_exp_t;

    typedef struct packed {
        logic       cache_re;
        logic       cache_we;
        logic       data_src;
        logic       first;
        logic       second;
        logic [1:0] w_sel;
    } hit_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr;
    logic        stall, index, hit, first, second, copy_back, cache_re, cache_we, cache_data_src;
    logic [3:0]  offset;
    logic [1:0]  w_sel, copy;

    data_cache_ctrl_if #(.ADDR_W(32)) mem_bus ();

    data_cache_ctrl #(.ADDR_W(32), .WORDS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .stall          (stall),
        .index          (index),
        .offset         (offset),
        .hit            (hit),
        .first          (first),
        .second         (second),
        .w_sel          (w_sel),
        .copy           (copy),
        .copy_back      (copy_back),
        .cache_re       (cache_re),
        .cache_we       (cache_we),
        .cache_data_src (cache_data_src),
        .mem            (mem_bus)
    );

    always #5 clk = ~clk;

    mem_exp_t    mem_q[$];
    hit_exp_t    hit_q[$];
    mem_exp_t    act_mem, exp_mem;
    hit_exp_t    act_hit, exp_hit;
    int          tests = 0;
    int          fails = 0;
    int          mem_accepts = 0;
    int          ready_delay = 0;
    int          wait_cnt = 0;
    logic        held_valid = 1'b0;
    logic [31:0] held_addr = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void pushFill(input logic [31:0] base, input logic way);
        for (int w = 0; w < 4; w++)
            mem_q.push_back('{we: 1'b0, addr: base + 32'(w * 4), copy_back: 1'b0, copy: 2'b00,
                              cache_re: 1'b0, cache_we: 1'b1, data_src: 1'b1,
                              first: ~way, second: way, w_sel: 2'(w)});
    endfunction

    function automatic void pushWb(input logic [31:0] base, input logic way, input int n);
        for (int w = 0; w < n; w++)
            mem_q.push_back('{we: 1'b1, addr: base + 32'(w * 4), copy_back: 1'b1, copy: {base[4], way},
                              cache_re: 1'b1, cache_we: 1'b0, data_src: 1'b0,
                              first: 1'b0, second: 1'b0, w_sel: 2'(w)});
    endfunction

    function automatic void pushHit(input logic re, input logic we, input logic [31:0] addr, input logic way);
        hit_q.push_back('{cache_re: re, cache_we: we & ~re, data_src: 1'b0,
                          first: ~way, second: way, w_sel: re ? addr[3:2] : 2'b00});
    endfunction

    // Memory model: ready every cycle, or after ready_delay low cycles for each word.
    initial begin
        mem_bus.mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ready_delay == 0) begin
                mem_bus.mem_ready = 1'b1;
            end else if (mem_bus.mem_ready) begin
                mem_bus.mem_ready = 1'b0;
                wait_cnt = 1;
            end else if (!mem_bus.mem_req) begin
                wait_cnt = 0;
            end else if (wait_cnt >= ready_delay) begin
                mem_bus.mem_ready = 1'b1;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Monitor: pops an expectation for every accepted bus word and every lookup hit.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_bus.mem_req && mem_bus.mem_ready) begin
                act_mem = {mem_bus.mem_we, mem_bus.mem_addr, copy_back, copy, cache_re, cache_we,
                           cache_data_src, first, second, w_sel};
                if (mem_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected mem transfer: got 0x%0h, expected none", act_mem);
                end else begin
                    exp_mem = mem_q.pop_front();
                    checkOutput("mem transfer", 64'(act_mem), 64'(exp_mem));
                end
                mem_accepts <= mem_accepts + 1;
            end
            if (mem_bus.mem_req) begin
                checkOutput("stall during miss", 64'(stall), 64'(1));
                if (!mem_bus.mem_ready) checkOutput("no array write while waiting", 64'(cache_we), 64'(0));
                if (held_valid) checkOutput("mem_addr held", 64'(mem_bus.mem_addr), 64'(held_addr));
            end
            held_valid <= mem_bus.mem_req && !mem_bus.mem_ready;
            held_addr  <= mem_bus.mem_addr;
            if (hit) begin
                act_hit = {cache_re, cache_we, cache_data_src, first, second, w_sel};
                if (hit_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected hit: got 0x%0h, expected none", act_hit);
                end else begin
                    exp_hit = hit_q.pop_front();
                    checkOutput("hit strobes", 64'(act_hit), 64'(exp_hit));
                end
                checkOutput("stall on hit", 64'(stall), 64'(0));
            end
        end else begin
            held_valid <= 1'b0;
        end
    end

    task automatic waitDone();
        bit done = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL access timeout: stall still %0b, expected 0", stall);
        end
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic applyStimulus(input logic re, input logic we, input logic [31:0] addr);
        @(posedge clk);
        #1;
        cpu_re   = re;
        cpu_we   = we;
        cpu_addr = addr;
        waitDone();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        bit reached;
        reset    = 1'b1;
        cpu_re   = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset stall", 64'(stall), 64'(0));
        checkOutput("reset mem_req", 64'(mem_bus.mem_req), 64'(0));
        checkOutput("reset strobes", 64'({hit, cache_re, cache_we, copy_back, mem_bus.mem_we}), 64'(0));
        checkOutput("reset mem_addr", 64'(mem_bus.mem_addr), 64'(0));
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cpu_re = 1'b0;
        @(negedge clk);
        checkOutput("idle strobes", 64'({stall, hit, first, second, cache_re, cache_we, mem_bus.mem_req}), 64'(0));

        // Cold read fills way 0 of set 1, then re-looks-up and hits.
        pushFill(32'h10, 1'b0);
        pushHit(1'b1, 1'b0, 32'h10, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h10);

        pushHit(1'b0, 1'b1, 32'h10, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h10);

        pushFill(32'h30, 1'b1);
        pushHit(1'b1, 1'b0, 32'h30, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h30);

        // Dirty way 0 (tag of 0x10) is the LRU victim.
        pushWb(32'h10, 1'b0, 4);
        pushFill(32'h50, 1'b0);
        pushHit(1'b1, 1'b0, 32'h50, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h50);

        ready_delay = 3;
        pushFill(32'h90, 1'b1);
        pushHit(1'b1, 1'b0, 32'h98, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h98);
        ready_delay = 0;

        pushHit(1'b0, 1'b1, 32'h50, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h50);
        pushHit(1'b0, 1'b1, 32'h94, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h94);

        // Reset in the middle of copying back the dirty 0x50 line.
        pushWb(32'h50, 1'b0, 2);
        @(posedge clk);
        #1;
        cpu_re   = 1'b1;
        cpu_addr = 32'h70;
        base     = mem_accepts;
        reached  = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            if (mem_accepts == base + 2) begin
                reached = 1;
                break;
            end
        end
        if (!reached) begin
            tests++;
            fails++;
            $display("[TB] FAIL wb progress: got %0d words, expected 2", mem_accepts - base);
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset mem_req", 64'(mem_bus.mem_req), 64'(0));
        checkOutput("post-reset miss stall", 64'(stall), 64'(1));
        checkOutput("post-reset no hit", 64'({hit, copy_back}), 64'(0));
        pushFill(32'h70, 1'b0);
        pushHit(1'b1, 1'b0, 32'h70, 1'b0);
        waitDone();

        // Set 0: combined load/store must behave as a read and leave the line clean.
        pushFill(32'h00, 1'b0);
        pushHit(1'b1, 1'b0, 32'h04, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h04);
        pushHit(1'b1, 1'b1, 32'h04, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h04);
        pushFill(32'h20, 1'b1);
        pushHit(1'b1, 1'b0, 32'h24, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h24);
        pushFill(32'h40, 1'b0);
        pushHit(1'b1, 1'b0, 32'h44, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h44);

        repeat (3) @(posedge clk);
        checkOutput("mem expectations left", 64'(mem_q.size()), 64'(0));
        checkOutput("hit expectations left", 64'(hit_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
